circle_gen: RTL

- Parametrised successor to the single-segment circle drawer used by the lab display path.
- Draws midpoint/Bresenham circle outlines into the VGA framebuffer writer via vga_x/vga_y/vga_colour/vga_plot.
- Replaces the compile-time segment selection with a runtime 8-bit octant mask, per-draw colour, and clipping to a parametrised screen size.
- Sits between the top-level drawing sequencer (start/done handshake) and the framebuffer adapter.

---
 rtl/circle_gen.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/circle_gen.sv
// Midpoint circle outline generator feeding the VGA framebuffer writer.
// Build with CIRCLE_GEN_FILL_EN defined to add the `fill` input (filled discs via span walks).
module circle_gen #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [X_W+1:0]        centre_x,
  input  logic [Y_W+1:0]        centre_y,
  input  logic [X_W:0]          radius,
  input  logic [7:0]            octant_mask,
  input  logic [COLOUR_W-1:0]   colour,
`ifdef CIRCLE_GEN_FILL_EN
  input  logic                  fill,
`endif
  output logic                  done,
  output logic [X_W-1:0]        vga_x,
  output logic [Y_W-1:0]        vga_y,
  output logic [COLOUR_W-1:0]   vga_colour,
  output logic                  vga_plot
);

  localparam int CW = X_W + 3;
  localparam int KW = X_W + 4;
  localparam logic signed [CW-1:0] SW_C  = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SH_C  = CW'(SCREEN_H);
  localparam logic signed [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [KW-1:0] ONE_K = {{(KW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_PLOT, S_UPDATE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic signed [CW-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic signed [CW-1:0]   ox_q, ox_d, oy_q, oy_d, s_q, s_d;
  logic signed [KW-1:0]   crit_q, crit_d;
  logic [X_W:0]           r_q, r_d;
  logic [7:0]             mask_q, mask_d;
  logic [COLOUR_W-1:0]    col_q, col_d;
  logic                   fill_q, fill_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      s_q     <= '0;
      crit_q  <= '0;
      r_q     <= '0;
      mask_q  <= '0;
      col_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      s_q     <= s_d;
      crit_q  <= crit_d;
      r_q     <= r_d;
      mask_q  <= mask_d;
      col_q   <= col_d;
      fill_q  <= fill_d;
    end
  end

  // Current point: one octant reflection, or a span pixel when filling rows.
  logic signed [CW-1:0] px, py, half;
  logic                 span;

  always_comb begin
    px   = cx_q + ox_q;
    py   = cy_q + oy_q;
    half = ox_q;
    span = fill_q && !k_q[2];
    case (k_q)
      3'd0: begin px = cx_q + ox_q; py = cy_q + oy_q; end
      3'd1: begin px = cx_q + oy_q; py = cy_q + ox_q; end
      3'd2: begin px = cx_q - oy_q; py = cy_q + ox_q; end
      3'd3: begin px = cx_q - ox_q; py = cy_q + oy_q; end
      3'd4: begin px = cx_q - ox_q; py = cy_q - oy_q; end
      3'd5: begin px = cx_q - oy_q; py = cy_q - ox_q; end
      3'd6: begin px = cx_q + oy_q; py = cy_q - ox_q; end
      default: begin px = cx_q + ox_q; py = cy_q - oy_q; end
    endcase
    if (span) begin
      half = k_q[1] ? oy_q : ox_q;
      px   = cx_q - half + s_q;
      case (k_q[1:0])
        2'd0:    py = cy_q + oy_q;
        2'd1:    py = cy_q - oy_q;
        2'd2:    py = cy_q + ox_q;
        default: py = cy_q - ox_q;
      endcase
    end
  end

  logic in_scr;
  assign in_scr = !px[CW-1] && (px < SW_C) && !py[CW-1] && (py < SH_C);

  // Update-step arithmetic, sign-extended into the wider criterion domain.
  logic signed [CW-1:0] oy_n, ox_n, ox_sel;
  logic signed [KW-1:0] oyk, dk;
  logic                 cle;

  always_comb begin
    oy_n   = oy_q + ONE_C;
    ox_n   = ox_q - ONE_C;
    cle    = crit_q[KW-1] || (crit_q == '0);
    ox_sel = cle ? ox_q : ox_n;
    oyk    = {oy_n[CW-1], oy_n};
    dk     = oyk - {ox_n[CW-1], ox_n};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    s_d     = s_q;
    crit_d  = crit_q;
    r_d     = r_q;
    mask_d  = mask_q;
    col_d   = col_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: if (start) begin
        cx_d    = {centre_x[X_W+1], centre_x};
        cy_d    = {{(CW-Y_W-2){centre_y[Y_W+1]}}, centre_y};
        r_d     = radius;
        mask_d  = octant_mask;
        col_d   = colour;
`ifdef CIRCLE_GEN_FILL_EN
        fill_d  = fill;
`else
        fill_d  = 1'b0;
`endif
        state_d = S_INIT;
      end
      S_INIT: begin
        ox_d    = {2'b00, r_q};
        oy_d    = '0;
        crit_d  = ONE_K - {3'b000, r_q};
        k_d     = 3'd0;
        s_d     = '0;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        if (span) begin
          if (s_q == {half[CW-2:0], 1'b0}) begin
            s_d = '0;
            if (k_q == 3'd3) state_d = S_UPDATE;
            else             k_d     = k_q + 3'd1;
          end else begin
            s_d = s_q + ONE_C;
          end
        end else if (k_q == 3'd7) begin
          state_d = S_UPDATE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_UPDATE: begin
        oy_d = oy_n;
        if (cle) begin
          crit_d = crit_q + {oyk[KW-2:0], 1'b0} + ONE_K;
        end else begin
          ox_d   = ox_n;
          crit_d = crit_q + {dk[KW-2:0], 1'b0} + ONE_K;
        end
        k_d     = 3'd0;
        state_d = (oy_n <= ox_sel) ? S_PLOT : S_DONE;
      end
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic in_plot;
  assign in_plot    = (state_q == S_PLOT);
  assign done       = (state_q == S_DONE);
  assign vga_plot   = in_plot && in_scr && (span || mask_q[k_q]);
  assign vga_x      = in_plot ? px[X_W-1:0] : '0;
  assign vga_y      = in_plot ? py[Y_W-1:0] : '0;
  assign vga_colour = in_plot ? col_q : '0;

endmodule
